// File: rtl/tlut_seq_ctrl_pkg.sv
// Shared types and derived constants for the temporal-LUT job sequencer.
// Vector typedefs are sized for the default cell geometry.
package tlut_seq_ctrl_pkg;

    localparam int P_DIM_A        = 4;
    localparam int P_DIM_C        = 4;
    localparam int P_INPUT_WIDTH  = 4;
    localparam int P_WEIGHT_WIDTH = 8;
    localparam int P_ACC_WIDTH    = 16;

    localparam int WINDOW = 32'd1 << P_INPUT_WIDTH;
    localparam int CNT_W  = P_INPUT_WIDTH + 32'd1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } seq_state_t;

    typedef logic [P_DIM_A*P_INPUT_WIDTH-1:0]          input_vec_t;
    typedef logic [P_DIM_C*P_WEIGHT_WIDTH-1:0]         weight_vec_t;
    typedef logic [P_DIM_C*P_DIM_A*P_ACC_WIDTH-1:0]    product_arr_t;

    function automatic int win_len(input int iw);
        return 32'd1 << iw;
    endfunction

endpackage

// File: rtl/tlut_window_cnt.sv
// Loadable up/down counter timing the LOAD, RUN and DRAIN phases.
// Terminal count: WINDOW-1 when counting up, zero when counting down.
module tlut_window_cnt #(
    parameter int CNT_W  = 5,
    parameter int WINDOW = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    input  logic             i_up,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_tc
);

    localparam logic [CNT_W-1:0] TC_UP   = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;

    // Counter register: clear beats load, load beats count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_clr) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en) begin
            r_cnt <= i_up ? (r_cnt + CNT_ONE) : (r_cnt - CNT_ONE);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = i_up ? (r_cnt == TC_UP) : (r_cnt == {CNT_W{1'b0}});

endmodule

// File: rtl/tlut_seq_ctrl.sv
// Job sequencer for one temporal-LUT SIMD cell: accept a job, clear and
// enable the cell for one temporal window, then hand the products downstream.
module tlut_seq_ctrl
    import tlut_seq_ctrl_pkg::*;
#(
    parameter int DIM_A        = P_DIM_A,
    parameter int DIM_C        = P_DIM_C,
    parameter int INPUT_WIDTH  = P_INPUT_WIDTH,
    parameter int WEIGHT_WIDTH = P_WEIGHT_WIDTH,
    parameter int ACC_WIDTH    = P_ACC_WIDTH,
    parameter int LOAD_LAT     = 1,
    parameter int DRAIN_LAT    = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DIM_A*INPUT_WIDTH-1:0]       in_input,
    input  logic [DIM_C*WEIGHT_WIDTH-1:0]      in_weight,
    output logic [DIM_A*INPUT_WIDTH-1:0]       cell_input_bin,
    output logic [DIM_C*WEIGHT_WIDTH-1:0]      cell_weight_bin,
    output logic                               cell_enable,
    output logic                               cell_clear,
    input  logic [DIM_C*DIM_A*ACC_WIDTH-1:0]   cell_product,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [DIM_C*DIM_A*ACC_WIDTH-1:0]   out_product,
    input  logic                               flush,
    output logic                               busy,
    output logic [15:0]                        jobs_done
);

    localparam int CW      = INPUT_WIDTH + 1;
    localparam int WIN_LEN = win_len(INPUT_WIDTH);

    localparam logic [CW-1:0] LOAD_TOP      = CW'(LOAD_LAT - 1);
    localparam logic [CW-1:0] DRAIN_TOP     = CW'(DRAIN_LAT - 1);
    localparam logic [CW-1:0] CNT_ONE       = CW'(1);
    localparam logic          CLR_ON_ACCEPT = (LOAD_TOP == {CW{1'b0}});

    seq_state_t                          r_state;
    logic                                r_in_ready;
    logic                                r_enable;
    logic                                r_clear;
    logic                                r_out_valid;
    logic                                r_busy;
    logic [DIM_A*INPUT_WIDTH-1:0]        r_input;
    logic [DIM_C*WEIGHT_WIDTH-1:0]       r_weight;
    logic [DIM_C*DIM_A*ACC_WIDTH-1:0]    r_out_product;
    logic [15:0]                         r_jobs_done;

    logic          w_accept;
    logic          w_cnt_load;
    logic [CW-1:0] w_cnt_load_val;
    logic          w_cnt_en;
    logic          w_cnt_up;
    logic [CW-1:0] w_cnt;
    logic          w_tc;

    assign w_accept = (r_state == S_IDLE) & r_in_ready & in_valid;
    assign w_cnt_up = (r_state == S_RUN);

    // Per-phase reload: each phase transition preloads the next phase's span.
    always_comb begin
        w_cnt_load     = 1'b0;
        w_cnt_load_val = {CW{1'b0}};
        w_cnt_en       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = LOAD_TOP;
                end else begin
                    w_cnt_load     = 1'b0;
                end
            end
            S_LOAD: begin
                if (w_tc) begin
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = {CW{1'b0}};
                end else begin
                    w_cnt_en       = 1'b1;
                end
            end
            S_RUN: begin
                if (w_tc) begin
                    w_cnt_load     = 1'b1;
                    w_cnt_load_val = DRAIN_TOP;
                end else begin
                    w_cnt_en       = 1'b1;
                end
            end
            S_DRAIN: begin
                if (w_tc) begin
                    w_cnt_en = 1'b0;
                end else begin
                    w_cnt_en = 1'b1;
                end
            end
            S_DONE:  w_cnt_en = 1'b0;
            default: w_cnt_en = 1'b0;
        endcase
    end

    tlut_window_cnt #(
        .CNT_W  (CW),
        .WINDOW (WIN_LEN)
    ) u_window_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (flush),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_en       (w_cnt_en),
        .i_up       (w_cnt_up),
        .o_cnt      (w_cnt),
        .o_tc       (w_tc)
    );

    // Sequencer FSM with registered handshake and cell controls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_in_ready    <= 1'b0;
            r_enable      <= 1'b0;
            r_clear       <= 1'b0;
            r_out_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_input       <= '0;
            r_weight      <= '0;
            r_out_product <= '0;
            r_jobs_done   <= 16'd0;
        end else if (flush) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_enable    <= 1'b0;
            r_clear     <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_input    <= in_input;
                        r_weight   <= in_weight;
                        r_state    <= S_LOAD;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_clear    <= CLR_ON_ACCEPT;
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (w_tc) begin
                        r_state  <= S_RUN;
                        r_clear  <= 1'b0;
                        r_enable <= 1'b1;
                    end else begin
                        // Counter reaches zero next cycle: that is the last LOAD cycle.
                        r_clear <= (w_cnt == CNT_ONE);
                    end
                end
                S_RUN: begin
                    if (w_tc) begin
                        r_state  <= S_DRAIN;
                        r_enable <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (w_tc) begin
                        r_state       <= S_DONE;
                        r_out_product <= cell_product;
                        r_jobs_done   <= r_jobs_done + 16'd1;
                        r_out_valid   <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b0;
                    r_enable    <= 1'b0;
                    r_clear     <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready        = r_in_ready;
    assign cell_input_bin  = r_input;
    assign cell_weight_bin = r_weight;
    assign cell_enable     = r_enable;
    assign cell_clear      = r_clear;
    assign out_valid       = r_out_valid;
    assign out_product     = r_out_product;
    assign busy            = r_busy;
    assign jobs_done       = r_jobs_done;

endmodule

// File: tb/tb_tlut_seq_ctrl.sv
// Self-checking bench for tlut_seq_ctrl with a behavioural temporal-LUT cell
// and a scoreboard of expected product arrays.
module tb_tlut_seq_ctrl;
    import tlut_seq_ctrl_pkg::*;

    localparam int DA = 4;
    localparam int DC = 4;
    localparam int IW = 4;
    localparam int WW = 8;
    localparam int AW = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    input_vec_t   in_input;
    weight_vec_t  in_weight;
    input_vec_t   cell_input_bin;
    weight_vec_t  cell_weight_bin;
    logic         cell_enable;
    logic         cell_clear;
    product_arr_t cell_product = '0;
    logic         out_valid;
    logic         out_ready;
    product_arr_t out_product;
    logic         flush;
    logic         busy;
    logic [15:0]  jobs_done;

    tlut_seq_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_input        (in_input),
        .in_weight       (in_weight),
        .cell_input_bin  (cell_input_bin),
        .cell_weight_bin (cell_weight_bin),
        .cell_enable     (cell_enable),
        .cell_clear      (cell_clear),
        .cell_product    (cell_product),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_product     (out_product),
        .flush           (flush),
        .busy            (busy),
        .jobs_done       (jobs_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural cell: each enabled cycle t adds the weight while t < input.
    int cell_t = 0;
    always @(posedge clk) begin
        if (cell_clear) begin
            cell_product <= '0;
            cell_t       <= 0;
        end else if (cell_enable) begin
            for (int c = 0; c < DC; c++)
                for (int a = 0; a < DA; a++)
                    if (cell_t < int'(cell_input_bin[a*IW +: IW]))
                        cell_product[(c*DA+a)*AW +: AW] <= cell_product[(c*DA+a)*AW +: AW]
                            + {{(AW-WW){1'b0}}, cell_weight_bin[c*WW +: WW]};
            cell_t <= cell_t + 1;
        end
    end

    function automatic product_arr_t ref_prod(input input_vec_t iv, input weight_vec_t wv);
        product_arr_t p;
        p = '0;
        for (int c = 0; c < DC; c++)
            for (int a = 0; a < DA; a++)
                p[(c*DA+a)*AW +: AW] = 16'(int'(iv[a*IW +: IW]) * int'(wv[c*WW +: WW]));
        return p;
    endfunction

    int n_tests = 0;
    int n_fail  = 0;
    int exp_jobs = 0;
    product_arr_t sb_q[$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Call at a negedge; returns just after the accepting posedge.
    task automatic accept_job(input input_vec_t iv, input weight_vec_t wv,
                              output int acc_cyc, output bit ok);
        ok       = 1'b0;
        acc_cyc  = -1;
        in_input  = iv;
        in_weight = wv;
        in_valid  = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (in_ready) begin
                acc_cyc = cyc;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!ok) begin
            in_valid = 1'b0;
            fail_now("accept_timeout");
        end else begin
            sb_q.push_back(ref_prod(iv, wv));
        end
    endtask

    // Full job with timing checks; ends at the negedge after the output handshake.
    task automatic run_job(input input_vec_t iv, input weight_vec_t wv, input int stall,
                           input logic [15:0] exp11, output int acc_cyc);
        bit ok;
        int clr_cnt, clr_first, en_cnt, en_first, en_last, valid_k;
        bit rdy_bad, hold_bad;
        product_arr_t held, exp_p;
        accept_job(iv, wv, acc_cyc, ok);
        if (!ok) return;
        clr_cnt = 0; clr_first = -1; en_cnt = 0; en_first = -1; en_last = -1;
        valid_k = -1; rdy_bad = 1'b0; hold_bad = 1'b0;
        for (int k = 1; k <= 40 && valid_k < 0; k++) begin
            @(negedge clk);
            if (cell_clear) begin clr_cnt++; if (clr_first < 0) clr_first = k; end
            if (cell_enable) begin en_cnt++; if (en_first < 0) en_first = k; en_last = k; end
            if (in_ready) rdy_bad = 1'b1;
            if (out_valid) valid_k = k;
        end
        chk("clear_cycle", clr_first, 1);
        chk("clear_once", clr_cnt, 1);
        chk("enable_first", en_first, 2);
        chk("enable_width", en_cnt, 16);
        chk("enable_last", en_last, 17);
        chk("out_valid_latency", valid_k, 20);
        chk("in_ready_busy_low", rdy_bad, 0);
        if (valid_k < 0) return;
        held = out_product;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if (!out_valid || out_product !== held || in_ready) hold_bad = 1'b1;
        end
        if (stall > 0) chk("backpressure_hold", hold_bad, 0);
        chk("operands_held", {cell_weight_bin, cell_input_bin}, {wv, iv});
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        if (sb_q.size() == 0) begin
            fail_now("scoreboard_empty");
        end else begin
            exp_p = sb_q.pop_front();
            chk("product_array", held, exp_p);
        end
        chk("product_el11", held[(1*DA+1)*AW +: AW], exp11);
        exp_jobs++;
        chk("jobs_done", jobs_done, exp_jobs % 65536);
        @(negedge clk);
        chk("out_valid_falls", out_valid, 0);
        chk("in_ready_after_hs", in_ready, 1);
    endtask

    typedef struct {
        input_vec_t  iv;
        weight_vec_t wv;
        int          stall;
        logic [15:0] exp11;
    } vec_t;

    vec_t tbl[4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc, prev_acc, prev_stall, dummy_acc;
        bit ok, bad;
        product_arr_t dropped;

        tbl[0] = '{iv: 16'h5555, wv: 32'h03030303, stall: 0,  exp11: 16'd15};
        tbl[1] = '{iv: 16'h81F0, wv: 32'h8001FF00, stall: 0,  exp11: 16'd3825};
        tbl[2] = '{iv: 16'hFFFF, wv: 32'hFFFFFFFF, stall: 10, exp11: 16'd3825};
        tbl[3] = '{iv: 16'h3927, wv: 32'h281E140A, stall: 3,  exp11: 16'd40};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_input = '0; in_weight = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_ctrl", {in_ready, busy, out_valid, cell_enable, cell_clear}, 5'b0);
        chk("reset_jobs", jobs_done, 0);
        chk("reset_product", out_product, 0);
        @(negedge clk);
        chk("reset_in_ready_rises", in_ready, 1);

        // Back-to-back table jobs; period is 21 cycles plus output stall.
        prev_acc = 0; prev_stall = 0;
        for (int i = 0; i < 4; i++) begin
            run_job(tbl[i].iv, tbl[i].wv, tbl[i].stall, tbl[i].exp11, acc);
            if (i > 0) chk("job_period", acc - prev_acc, 21 + prev_stall);
            prev_acc = acc;
            prev_stall = tbl[i].stall;
        end

        // Flush in RUN at window count 7.
        accept_job(16'h4321, 32'h01020304, dummy_acc, ok);
        repeat (9) @(negedge clk);
        chk("flush_pre_enable", cell_enable, 1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        if (sb_q.size() > 0) dropped = sb_q.pop_back();
        @(negedge clk);
        chk("flush_enable_off", cell_enable, 0);
        chk("flush_idle", {busy, in_ready}, 2'b01);
        chk("flush_jobs_kept", jobs_done, exp_jobs);
        bad = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (out_valid || cell_enable) bad = 1'b1;
        end
        chk("flush_no_output", bad, 0);
        run_job(16'hA5C3, 32'h11223344, 0, 16'h33 * 16'hC, acc);

        // Flush coinciding with an IDLE handshake drops the job.
        in_input = 16'h1111; in_weight = 32'h01010101;
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; flush = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (busy || cell_clear || !in_ready) bad = 1'b1;
        end
        chk("flush_hs_dropped", bad, 0);

        // Reset together with flush while draining.
        accept_job(16'h7777, 32'h05050505, dummy_acc, ok);
        repeat (18) @(negedge clk);
        chk("drain_busy", {busy, cell_enable}, 2'b10);
        rst = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; flush = 1'b0;
        if (sb_q.size() > 0) dropped = sb_q.pop_back();
        exp_jobs = 0;
        @(negedge clk);
        chk("rst_ctrl", {in_ready, busy, out_valid, cell_enable, cell_clear}, 5'b0);
        chk("rst_jobs", jobs_done, 0);
        chk("rst_product", out_product, 0);
        chk("rst_operands", {cell_weight_bin, cell_input_bin}, 0);
        @(negedge clk);
        chk("rst_in_ready_rises", in_ready, 1);
        run_job(16'h2468, 32'hFF807F01, 2, 16'd6 * 16'h7F, acc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tlut_seq_ctrl.md
Name: tlut_seq_ctrl

Overview:
Job sequencer for the temporal-LUT SIMD multiply cell. It accepts one operand job (DIM_A inputs, DIM_C weights) over a valid/ready handshake, loads the cell, clears its accumulators, and drives cell enable for exactly one temporal window of 2^INPUT_WIDTH cycles. After the pipeline drains it captures the DIM_C×DIM_A product array and presents it downstream over a second valid/ready handshake. It sits between the operand fetch/buffer logic and one simd_cell instance.

Parameters:
DIM_A, 4, input lanes per job
DIM_C, 4, weight lanes per job
INPUT_WIDTH, 4, input bits; temporal window = 2^INPUT_WIDTH cycles
WEIGHT_WIDTH, 8, weight bits
ACC_WIDTH, 16, product/accumulator width
LOAD_LAT, 1, cycles from operand drive to cell registers valid (>=1)
DRAIN_LAT, 2, cycles after last enable before cell products are stable (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  job offered
in_ready  out  1  controller can accept job
in_input  in  DIM_A*INPUT_WIDTH  job inputs, unsigned
in_weight  in  DIM_C*WEIGHT_WIDTH  job weights
cell_input_bin  out  DIM_A*INPUT_WIDTH  to cell input register
cell_weight_bin  out  DIM_C*WEIGHT_WIDTH  to cell weight register
cell_enable  out  1  cell enable (temporal window)
cell_clear  out  1  one-cycle clear of cell accumulators/counter
cell_product  in  DIM_C*DIM_A*ACC_WIDTH  cell product array
out_valid  out  1  result available
out_ready  in  1  downstream accepts result
out_product  out  DIM_C*DIM_A*ACC_WIDTH  captured result
flush  in  1  synchronous abort
busy  out  1  state != IDLE
jobs_done  out  16  completed-job count, wraps

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; in_ready, cell_enable, cell_clear, out_valid, busy = 0; operand holding regs, out_product, window counter, jobs_done = 0. in_ready=1 from the first cycle after rst deasserts.
- States: IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, latch in_input/in_weight into holding regs. Next state is LOAD.
- cell_input_bin/cell_weight_bin are driven from the holding regs at all times. They are stable from LOAD through DONE.
- LOAD: lasts LOAD_LAT cycles. cell_clear=1 in the last LOAD cycle only. Then RUN.
- RUN: cell_enable=1 for exactly 2^INPUT_WIDTH consecutive cycles. The window counter counts 0..2^INPUT_WIDTH-1 and moves to DRAIN when count = max. The counter is INPUT_WIDTH+1 bits wide, so the terminal count does not alias.
- DRAIN: cell_enable=0 for DRAIN_LAT cycles. On the last DRAIN cycle edge, out_product <= cell_product and jobs_done increments (mod 2^16). Then DONE.
- DONE: out_valid=1 and out_product is held stable. On out_valid&out_ready, go to IDLE. out_valid falls the next cycle.
- No back-to-back accept: in_ready=0 outside IDLE.
- Minimum job period: 1 + LOAD_LAT + 2^INPUT_WIDTH + DRAIN_LAT + 1 cycles, plus any out_ready stall. Defaults give an accept at cycle 0, clear at cycle 1, enable over cycles 2..17, drain over 18..19, and out_valid from cycle 20.
- flush=1 at any edge returns to IDLE and clears cell_enable, out_valid and the window counter. out_product and jobs_done are unchanged. The in-flight job is discarded without a count. rst has priority over flush.
- flush in the same cycle as an IDLE handshake: the job is dropped and the state stays IDLE.
- out_ready held high while in DONE: the handshake completes in the first DONE cycle.
- in_valid while not in IDLE is ignored. The upstream must hold the job until in_ready.
- No arithmetic is performed here. out_product is a bit-exact copy of cell_product.

Decomposition:
- Shared package holds:
  - the state enum;
  - derived localparams: WINDOW = 2^INPUT_WIDTH, CNT_W = INPUT_WIDTH+1;
  - packed typedefs for the input vector, weight vector and product array, reused by simd_cell wrappers.
- One natural sub-module: tlut_window_cnt. It is a loadable down/up counter with a terminal-count flag, shared by the LOAD, RUN and DRAIN timing (reload value selected per state).

Test Plan:
- Single job, all inputs=5, all weights=3, behavioural cell model, defaults → cell_clear only at cycle 1, cell_enable high for exactly cycles 2..17 (16 cycles), out_valid at cycle 20, every out_product element = 15, jobs_done=1.
- Boundary operands: inputs {0,15,1,8}, weights {0,255,1,128} → products match the model (e.g. 15*255=3825), and enable width is still exactly 16 cycles.
- Backpressure: out_ready=0 for 10 cycles in DONE → out_valid and out_product stable, in_ready=0 throughout, and the next job is accepted the cycle after the handshake.
- flush in RUN at window count 7 → cell_enable=0 next cycle, state IDLE, out_valid never asserted, jobs_done unchanged, and the following job completes correctly.
- rst asserted in DRAIN concurrent with flush → all outputs are at reset values next cycle and in_ready=1 one cycle after rst drops.
- Wrap: 65536 back-to-back jobs with out_ready=1 and LOAD_LAT=DRAIN_LAT=1 → jobs_done wraps to 0, and each job period is exactly 20 cycles.
